stim_gen: RTL and testbench

- Synthesizable, parametrised stimulus source for filter and up/downsampler verification, and for on-board hardware test.
- Generalises the ad-hoc periodic-impulse driver into a block with five modes: zero, periodic impulse, step, 4-ASK PRBS symbols and finite burst.
- Runs on the system clock and is paced by the existing sam_clk_en and sym_clk_en strobes from the clocks block.
- Drives x_in of the transmit filter and polyphase blocks directly.

---
 rtl/stim_gen_pkg.sv | 34 +++
 rtl/prbs_lfsr22.sv | 33 +++
 rtl/stim_gen.sv | 143 ++++++++++++++
 tb/tb_stim_gen.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stim_gen_pkg.sv
// Shared types and constants for the stimulus generator and its PRBS source.
package stim_gen_pkg;

  typedef enum logic [2:0] {
    MODE_ZERO    = 3'd0,
    MODE_IMPULSE = 3'd1,
    MODE_STEP    = 3'd2,
    MODE_PRBS    = 3'd3,
    MODE_BURST   = 3'd4
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int unsigned LFSR_LEN    = 22;
  localparam int unsigned LFSR_TAP_HI = 21;
  localparam int unsigned LFSR_TAP_LO = 20;

  // Gray-coded 4-ASK: adjacent levels differ in one bit.
  function automatic int gray_level(input logic [1:0] sym, input int amp);
    int third;
    third = amp / 3;
    case (sym)
      2'b00:   return -amp;
      2'b01:   return -third;
      2'b11:   return third;
      default: return amp;
    endcase
  endfunction

endpackage

// File: rtl/prbs_lfsr22.sv
// Fibonacci LFSR for x^22+x^21+1; sym_bits previews the two LSBs after the next shift.
module prbs_lfsr22
  import stim_gen_pkg::*;
#(
  parameter logic [LFSR_LEN-1:0] SEED = '1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                shift,
  output logic [LFSR_LEN-1:0] q,
  output logic [1:0]          sym_bits
);

  logic [LFSR_LEN-1:0] q_q;
  logic                fb;

  assign fb = q_q[LFSR_TAP_HI] ^ q_q[LFSR_TAP_LO];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= SEED;
    end else if (load) begin
      q_q <= SEED;
    end else if (shift) begin
      q_q <= {q_q[LFSR_LEN-2:0], fb};
    end
  end

  assign q        = q_q;
  assign sym_bits = {q_q[0], fb};

endmodule

// File: rtl/stim_gen.sv
// Strobe-paced stimulus source: zero, periodic impulse, step, 4-ASK PRBS and finite burst.
module stim_gen
  import stim_gen_pkg::*;
#(
  parameter int unsigned         WIDTH       = 18,
  parameter int unsigned         AMP         = 131071,
  parameter int unsigned         PERIOD      = 1000,
  parameter int unsigned         IMPULSE_POS = 200,
  parameter int unsigned         NUM_FRAMES  = 4,
  parameter logic [LFSR_LEN-1:0] LFSR_SEED   = 22'h3FFFFF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sam_clk_en,
  input  logic                    sym_clk_en,
  input  logic [2:0]              mode,
  input  logic                    start,
  input  logic                    stop,
  output logic signed [WIDTH-1:0] x_out,
  output logic                    frame_start,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned C_W = $clog2(PERIOD);
  localparam int unsigned F_W = $clog2(NUM_FRAMES + 1);

  localparam logic [C_W-1:0]          C_LAST = C_W'(PERIOD - 1);
  localparam logic [C_W-1:0]          C_POS  = C_W'(IMPULSE_POS);
  localparam logic [F_W-1:0]          F_LAST = F_W'(NUM_FRAMES - 1);
  localparam logic [F_W-1:0]          F_MAX  = '1;
  localparam logic signed [WIDTH-1:0] AMP_W  = WIDTH'(AMP);

  state_e                    state_q, state_d;
  logic [2:0]                mode_q, mode_d;
  logic [C_W-1:0]            c_q, c_d;
  logic [F_W-1:0]            f_q, f_d;
  logic signed [WIDTH-1:0]   x_q, x_d;
  logic                      fs_q, fs_d;
  logic                      busy_q, done_q;
  logic                      lfsr_load, lfsr_shift;
  logic [LFSR_LEN-1:0]       lfsr_q;
  logic [1:0]                sym_bits;

  prbs_lfsr22 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .load     (lfsr_load),
    .shift    (lfsr_shift),
    .q        (lfsr_q),
    .sym_bits (sym_bits)
  );

  // Next-state and output logic; stop has priority over start everywhere.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    c_d        = c_q;
    f_d        = f_q;
    x_d        = x_q;
    fs_d       = 1'b0;
    lfsr_load  = (lfsr_q == '0);
    lfsr_shift = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (start) begin
          state_d   = S_RUN;
          mode_d    = mode;
          c_d       = '0;
          f_d       = '0;
          x_d       = '0;
          lfsr_load = 1'b1;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
          x_d     = '0;
        end else if (sam_clk_en) begin
          fs_d = (c_q == '0);
          if (c_q == C_LAST) begin
            c_d = '0;
            f_d = (f_q == F_MAX) ? f_q : f_q + F_W'(1);
          end else begin
            c_d = c_q + C_W'(1);
          end

          case (mode_q)
            MODE_IMPULSE, MODE_BURST: x_d = (c_q == C_POS) ? AMP_W : '0;
            MODE_STEP:                x_d = ((f_q == '0) && (c_q < C_POS)) ? '0 : AMP_W;
            MODE_PRBS: begin
              if (sym_clk_en) begin
                lfsr_shift = 1'b1;
                x_d        = WIDTH'(gray_level(sym_bits, int'(AMP)));
              end
            end
            default:                  x_d = '0;
          endcase

          // Last sample of the last burst frame ends the run.
          if ((mode_q == MODE_BURST) && (c_q == C_LAST) && (f_q == F_LAST)) begin
            state_d = S_DONE;
            x_d     = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      c_q     <= '0;
      f_q     <= '0;
      x_q     <= '0;
      fs_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      c_q     <= c_d;
      f_q     <= f_d;
      x_q     <= x_d;
      fs_q    <= fs_d;
      busy_q  <= (state_d == S_RUN);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign x_out       = x_q;
  assign frame_start = fs_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_stim_gen.sv
// Directed bench for stim_gen: a strobe-count model checked every cycle plus hand-computed pins.
module tb_stim_gen;

  localparam int          WIDTH       = 18;
  localparam int          AMP         = 131071;
  localparam int          PERIOD      = 1000;
  localparam int          IMPULSE_POS = 200;
  localparam int          NUM_FRAMES  = 4;
  localparam logic [21:0] SEED        = 22'h3FFFFF;
  localparam int          NSYM        = 1024;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    sam_clk_en = 1'b0;
  logic                    sym_clk_en = 1'b0;
  logic [2:0]              mode = 3'd0;
  logic                    start = 1'b0;
  logic                    stop = 1'b0;
  logic signed [WIDTH-1:0] x_out;
  logic                    frame_start;
  logic                    busy;
  logic                    done;

  int chk_total = 0;
  int chk_pass  = 0;
  int sam_div   = 1;
  int dcnt      = 0;
  int scnt      = 0;
  int gold [0:NSYM-1];
  bit s    [0:NSYM+22];

  stim_gen #(
    .WIDTH       (WIDTH),
    .AMP         (AMP),
    .PERIOD      (PERIOD),
    .IMPULSE_POS (IMPULSE_POS),
    .NUM_FRAMES  (NUM_FRAMES),
    .LFSR_SEED   (SEED)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sam_clk_en  (sam_clk_en),
    .sym_clk_en  (sym_clk_en),
    .mode        (mode),
    .start       (start),
    .stop        (stop),
    .x_out       (x_out),
    .frame_start (frame_start),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Sample strobe every sam_div clocks; symbol strobe on every fourth sample strobe.
  always @(negedge clk) begin
    if (dcnt == 0) begin
      sam_clk_en <= 1'b1;
      sym_clk_en <= (scnt == 0);
      scnt       <= (scnt + 1) % 4;
    end else begin
      sam_clk_en <= 1'b0;
      sym_clk_en <= 1'b0;
    end
    dcnt <= (dcnt + 1 >= sam_div) ? 0 : dcnt + 1;
  end

  task automatic check(input string name, input longint act, input longint exp);
    chk_total++;
    if (act == exp) chk_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  function automatic int level(input bit b1, input bit b0);
    case ({b1, b0})
      2'b00:   return -AMP;
      2'b01:   return -(AMP / 3);
      2'b11:   return AMP / 3;
      default: return AMP;
    endcase
  endfunction

  // Model: n counts sample strobes since start; index = n % PERIOD, frame = n / PERIOD.
  logic       m_run, m_done, exp_fs;
  logic [2:0] m_mode;
  int         n, sym_k, exp_x;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_run  <= 1'b0;
      m_done <= 1'b0;
      m_mode <= 3'd0;
      n      <= 0;
      sym_k  <= 0;
      exp_x  <= 0;
      exp_fs <= 1'b0;
    end else begin
      exp_fs <= 1'b0;
      if (stop) begin
        m_run  <= 1'b0;
        m_done <= 1'b0;
        exp_x  <= 0;
      end else if (start && !m_run) begin
        m_run  <= 1'b1;
        m_done <= 1'b0;
        m_mode <= mode;
        n      <= 0;
        sym_k  <= 0;
        exp_x  <= 0;
      end else if (m_run && sam_clk_en) begin
        n      <= n + 1;
        exp_fs <= (n % PERIOD == 0);
        case (m_mode)
          3'd1: exp_x <= (n % PERIOD == IMPULSE_POS) ? AMP : 0;
          3'd2: exp_x <= (n >= IMPULSE_POS) ? AMP : 0;
          3'd3: if (sym_clk_en) begin
                  sym_k <= sym_k + 1;
                  exp_x <= (sym_k + 1 < NSYM) ? gold[sym_k + 1] : 0;
                end
          3'd4: if (n == PERIOD * NUM_FRAMES - 1) begin
                  m_run  <= 1'b0;
                  m_done <= 1'b1;
                  exp_x  <= 0;
                end else begin
                  exp_x <= (n % PERIOD == IMPULSE_POS) ? AMP : 0;
                end
          default: exp_x <= 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    check("x_out", longint'(x_out), longint'(exp_x));
    check("frame_start", longint'(frame_start), longint'(exp_fs));
    check("busy", longint'(busy), longint'(m_run));
    check("done", longint'(done), longint'(m_done));
  end

  task automatic pulse(input logic s_start, input logic s_stop, input logic [2:0] s_mode);
    mode  = s_mode;
    start = s_start;
    stop  = s_stop;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  initial begin
    int found;
    // Golden PRBS: s[n] = s[n-22] ^ s[n-21]; symbol m uses {s[m+20], s[m+21]}.
    for (int i = 0; i < 22; i++) s[21 - i] = SEED[i];
    for (int k = 22; k <= NSYM + 22; k++) s[k] = s[k - 22] ^ s[k - 21];
    gold[0] = 0;
    for (int m = 1; m < NSYM; m++) gold[m] = level(s[m + 20], s[m + 21]);
    check("gold_sym1", longint'(gold[1]), 131071);
    check("gold_sym2", longint'(gold[2]), -131071);
    check("gold_sym22", longint'(gold[22]), -43690);

    // Reset held ~500 ns with strobes and a start pulse.
    #1 reset = 1'b0;
    sam_div = 2;
    cycles(20);
    pulse(1'b1, 1'b0, 3'd1);
    cycles(30);
    check("reset_x", longint'(x_out), 0);
    #3 reset = 1'b1;
    cycles(20);
    check("idle_busy", longint'(busy), 0);

    // start and stop together in IDLE.
    sam_div = 1;
    pulse(1'b1, 1'b1, 3'd1);
    cycles(2);
    check("startstop_busy", longint'(busy), 0);

    // Impulse mode.
    pulse(1'b1, 1'b0, 3'd1);
    @(negedge clk);
    check("imp_fs0", longint'(frame_start), 1);
    cycles(199);
    check("imp_199", longint'(x_out), 0);
    cycles(1);
    check("imp_200", longint'(x_out), 131071);
    cycles(1);
    check("imp_201", longint'(x_out), 0);
    cycles(3000 - 202);
    pulse(1'b0, 1'b1, 3'd0);

    // Burst mode.
    pulse(1'b1, 1'b0, 3'd4);
    cycles(3999);
    check("burst_busy_3998", longint'(busy), 1);
    cycles(1);
    check("burst_done", longint'(done), 1);
    check("burst_busy_end", longint'(busy), 0);
    cycles(50);
    pulse(1'b0, 1'b1, 3'd4);
    check("burst_stop_done", longint'(done), 0);
    sam_div = 2;
    pulse(1'b1, 1'b0, 3'd4);
    cycles(8100);
    check("burst2_done", longint'(done), 1);
    pulse(1'b0, 1'b1, 3'd0);

    // Step mode, mode input changed mid-run, then stopped mid-frame.
    pulse(1'b1, 1'b0, 3'd2);
    cycles(600);
    mode = 3'd1;
    cycles(800);
    check("step_high", longint'(x_out), 131071);
    pulse(1'b0, 1'b1, 3'd1);
    check("step_stop_x", longint'(x_out), 0);
    check("step_stop_busy", longint'(busy), 0);

    // PRBS mode with a start pulse during RUN.
    sam_div = 1;
    pulse(1'b1, 1'b0, 3'd3);
    cycles(1000);
    pulse(1'b1, 1'b0, 3'd3);
    cycles(1000);
    pulse(1'b0, 1'b1, 3'd0);

    // Out-of-range mode behaves as zero.
    pulse(1'b1, 1'b0, 3'd5);
    cycles(100);
    pulse(1'b0, 1'b1, 3'd0);

    // Reset asserted mid-run, then PRBS restarts from seed at c=0.
    pulse(1'b1, 1'b0, 3'd2);
    cycles(500);
    check("pre_reset_x", longint'(x_out), 131071);
    #3 reset = 1'b0;
    #1;
    check("async_reset_x", longint'(x_out), 0);
    check("async_reset_busy", longint'(busy), 0);
    cycles(5);
    #3 reset = 1'b1;
    @(negedge clk);
    pulse(1'b1, 1'b0, 3'd3);
    @(negedge clk);
    check("restart_fs0", longint'(frame_start), 1);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      if (x_out != 0) found = 1;
      else @(negedge clk);
    end
    check("prbs_first_wait", longint'(found), 1);
    check("prbs_first_sym", longint'(x_out), 131071);
    cycles(200);
    pulse(1'b0, 1'b1, 3'd0);
    cycles(5);

    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

endmodule
